// File: rtl/bank_response_queue.sv
// Per-bank response FIFO: stamps each entry with global_cycle on enqueue, reports queue age on dequeue.
// Entries appear at the head one cycle after the enqueue edge; enq_ready drops only when full, with no bypass or pass-through.
module bank_response_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [63:0]                  global_cycle,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [ID_W-1:0]              enq_request_id,
  input  logic [ADDR_W-1:0]            enq_addr,
  input  logic [DATA_W-1:0]            enq_data,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [ID_W-1:0]              deq_request_id,
  output logic [ADDR_W-1:0]            deq_addr,
  output logic [DATA_W-1:0]            deq_data,
  output logic [31:0]                  deq_latency,
  output logic                         resp_fire,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0]   max_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [63:0]       stamp;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head_ent;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count_next;
  logic              enq_fire;
  logic              deq_fire;
  logic [63:0]       age;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign enq_ready = (count != CNT_W'(DEPTH));
  assign deq_valid = (count != '0);
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;
  assign resp_fire = deq_fire;

  always_comb begin
    count_next = count;
    case ({enq_fire, deq_fire})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      max_count <= '0;
    end else begin
      if (enq_fire) tail <= wrap_inc(tail);
      if (deq_fire) head <= wrap_inc(head);
      count <= count_next;
      if (count_next > max_count) max_count <= count_next;
    end
  end

  // Storage needs no reset: every head read is gated by deq_valid.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem[tail] <= '{id: enq_request_id, addr: enq_addr, data: enq_data, stamp: global_cycle};
    end
  end

  assign head_ent = mem[head];
  assign age      = global_cycle - head_ent.stamp;

  always_comb begin
    deq_request_id = '0;
    deq_addr       = '0;
    deq_data       = '0;
    deq_latency    = '0;
    if (deq_valid) begin
      deq_request_id = head_ent.id;
      deq_addr       = head_ent.addr;
      deq_data       = head_ent.data;
      deq_latency    = (|age[63:32]) ? 32'hFFFF_FFFF : age[31:0];
    end
  end

endmodule
